// File: rtl/sb_pkg.sv
// Shared types and helpers for the store buffer.
// Optional build macro: STORE_BUFFER_FORWARD_EN (store-to-load forwarding).
package sb_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;
  localparam int unsigned SB_WIDTH         = 32;

  // One buffered store: byte address and data
  typedef struct packed {
    logic [SB_WIDTH-1:0] addr;
    logic [SB_WIDTH-1:0] data;
  } sb_entry_t;

  // Pointer width for a power-of-two depth
  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Associative word-address compare across valid buffer entries with
// youngest-first priority. Used for forwarding data or for stall-on-match.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = SB_WIDTH
) (
  input  logic [WIDTH-3:0]              load_tag,
  input  logic [WIDTH-3:0]              entry_tag   [DEPTH],
  input  logic [WIDTH-1:0]              entry_data  [DEPTH],
  input  logic [DEPTH-1:0]              entry_valid,
  input  logic [sb_ptr_w(DEPTH)-1:0]    head,
  output logic                          hit,
  output logic [WIDTH-1:0]              data
);

  localparam int unsigned PW = sb_ptr_w(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest from head; a later match overrides an earlier one
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = PW'(head + PW'(k));
      if (entry_valid[idx] && (entry_tag[idx] == load_tag)) begin
        hit  = 1'b1;
        data = entry_data[idx];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer between the Memory stage and data memory.
// Circular FIFO of stores drained through a req/ready write port.
// Optional build macro: STORE_BUFFER_FORWARD_EN -- when defined, loads that
// hit a buffered store get the youngest matching data; otherwise such loads
// stall until the matching stores have drained.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned WIDTH = SB_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWriteM,
  input  logic             MemReadM,
  input  logic             SyncM,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [WIDTH-1:0] ReadDataMem,
  input  logic             mem_ready,
  output logic [WIDTH-1:0] ReadDataM,
  output logic [WIDTH-1:0] mem_raddr,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             StallSB,
  output logic             SBEmpty,
  output logic [4:0]       SBCount
);

  localparam int unsigned PW = sb_ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Elaboration guards on the parameter space
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("store_buffer: DEPTH must be a power of two between 2 and 16");
  end
  if (WIDTH != SB_WIDTH) begin : g_bad_width
    $error("store_buffer: WIDTH must match sb_pkg::SB_WIDTH (entry type size)");
  end

  sb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             is_store;
  logic             is_load;
  logic             sb_full;
  logic             sb_empty;
  logic             sync_stall;
  logic             full_stall;
  logic             hit_stall;
  logic             enq;
  logic             deq;

  logic [WIDTH-3:0] ent_tag  [DEPTH];
  logic [WIDTH-1:0] ent_data [DEPTH];
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;

  // Access classification, stall sources and FIFO handshakes
  always_comb begin
    is_store   = MemWriteM;
    is_load    = MemReadM & ~MemWriteM;
    sb_full    = (count == CW'(DEPTH));
    sb_empty   = (count == '0);
    sync_stall = SyncM & ~sb_empty;
    full_stall = is_store & sb_full;
    enq        = is_store & ~sb_full & ~sync_stall;
    deq        = ~sb_empty & mem_ready;
  end

`ifdef STORE_BUFFER_FORWARD_EN
  assign hit_stall = 1'b0;
`else
  assign hit_stall = is_load & fwd_hit;
`endif

  assign StallSB = full_stall | sync_stall | hit_stall;

  // Drain port presents the head entry whenever anything is buffered
  always_comb begin
    mem_req   = ~sb_empty;
    mem_we    = ~sb_empty;
    mem_addr  = entries[head].addr;
    mem_wdata = entries[head].data;
    SBEmpty   = sb_empty;
    SBCount   = 5'(count);
    mem_raddr = ALUOutM;
  end

  // Split entries into compare tags and data for the matcher
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ent_tag[i]  = entries[i].addr[WIDTH-1:2];
      ent_data[i] = entries[i].data;
    end
  end

  sb_fwd_match #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_match (
    .load_tag    (ALUOutM[WIDTH-1:2]),
    .entry_tag   (ent_tag),
    .entry_data  (ent_data),
    .entry_valid (valid),
    .head        (head),
    .hit         (fwd_hit),
    .data        (fwd_data)
  );

`ifdef STORE_BUFFER_FORWARD_EN
  assign ReadDataM = (is_load && fwd_hit) ? fwd_data : ReadDataMem;
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^fwd_data;
  assign ReadDataM       = ReadDataMem;
`endif

  // Pointers, occupancy and valid bits
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (enq) begin
        tail        <= PW'(tail + PW'(1));
        valid[tail] <= 1'b1;
      end
      if (deq) begin
        head        <= PW'(head + PW'(1));
        valid[head] <= 1'b0;
      end
      case ({enq, deq})
        2'b10:   count <= CW'(count + CW'(1));
        2'b01:   count <= CW'(count - CW'(1));
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; contents are qualified by valid, so no reset
  always_ff @(posedge clk) begin
    if (enq) begin
      entries[tail].addr <= ALUOutM;
      entries[tail].data <= WriteDataM;
    end
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the ports are clk and reset.
REQ-002 Parameter DEPTH SHALL default to 4 and set the number of entries; legal values are powers of two from 2 to 16.
REQ-003 Parameter WIDTH SHALL default to 32 and set the address and data width.
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- MemWriteM  in  1  store in the Memory stage.
- MemReadM  in  1  load in the Memory stage.
- SyncM  in  1  barrier; hold the pipeline until the buffer is empty.
- ALUOutM  in  WIDTH  byte address of the access.
- WriteDataM  in  WIDTH  store data.
- ReadDataMem  in  WIDTH  combinational read data from data memory.
- mem_ready  in  1  memory write port accepts the offered write.
- ReadDataM  out  WIDTH  load result to the Writeback pipeline register.
- mem_raddr  out  WIDTH  read address to data memory.
- mem_req  out  1  write offered to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  WIDTH  address of the offered write.
- mem_wdata  out  WIDTH  data of the offered write.
- StallSB  out  1  stall request to the hazard unit.
- SBEmpty  out  1  no valid entries.
- SBCount  out  5  number of valid entries.

Function
REQ-005 The buffer SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus a count of 0..DEPTH.
REQ-006 Enqueue:
- a store with count<DEPTH SHALL write {ALUOutM, WriteDataM} at tail on the clock edge;
- the tail pointer and count advance by 1.
REQ-007 Full:
- a store with count==DEPTH SHALL assert StallSB and SHALL NOT enqueue, even if a drain completes in the same cycle;
- the store enqueues in the first cycle after count drops.
REQ-008 Drain request: mem_req and mem_we SHALL equal (count!=0); mem_addr and mem_wdata SHALL present the head entry.
REQ-009 Drain completion: the transfer completes when mem_req&mem_ready; the head pointer advances and count decrements on that edge.
REQ-010 While mem_req&~mem_ready, mem_addr and mem_wdata SHALL hold stable.
REQ-011 Write latency: a store into an empty buffer SHALL appear on mem_req exactly one cycle later; there is no combinational bypass to memory.
REQ-012 Simultaneous enqueue and drain completion SHALL leave count unchanged and advance both pointers.
REQ-013 Loads:
- mem_raddr SHALL equal ALUOutM combinationally;
- ReadDataM SHALL equal ReadDataMem unless overridden by REQ-014/015.
REQ-014 With forwarding compiled in, a load whose ALUOutM[WIDTH-1:2] matches any valid entry SHALL return the data of the youngest matching entry, combinationally.
- The entry being drained in the current cycle counts as valid for matching.
REQ-015 With forwarding compiled out, a load matching any valid entry SHALL assert StallSB until no valid entry matches; ReadDataM then comes from memory.
REQ-016 If SyncM is asserted, StallSB SHALL be asserted while count!=0, and deasserted combinationally in the cycle count==0.
REQ-017 If MemWriteM and MemReadM are both high, the access SHALL be treated as a store, and ReadDataM SHALL equal ReadDataMem.
REQ-018 SBEmpty SHALL equal (count==0); SBCount SHALL equal count, zero-extended.

Reset
REQ-019 On reset:
- count, head and tail SHALL be 0 and all entries invalid;
- mem_req, mem_we, StallSB and SBCount SHALL be 0, and SBEmpty SHALL be 1.
REQ-020 A reset during a pending drain SHALL discard all entries without completing the write; mem_req is low in the cycle after reset.

Configuration
REQ-021 Macro STORE_BUFFER_FORWARD_EN:
- defined: REQ-014 forwarding is built;
- undefined: no match data path is built, and REQ-015 stall-on-match applies.

Structure
REQ-022 Package sb_pkg SHALL hold the entry type {addr, data}, the DEPTH default, and the pointer-width function.
REQ-023 Sub-module sb_fwd_match SHALL perform the associative compare and youngest-first priority select.
- It outputs hit and data.
- It is instantiated in both configurations: the hit output drives the stall, and the data output is used only with forwarding.

Verification
REQ-024 Reset, then store 0x100←0xAAAA0001 with mem_ready=1 -> mem_req=1 next cycle with addr 0x100, data 0xAAAA0001; count 1→0 after one cycle.
REQ-025 mem_ready=0, five stores to 0x0,0x4,0x8,0xC,0x10 with DEPTH=4 -> count=4 and StallSB=1 on the fifth store; raise mem_ready -> the fifth store enqueues one cycle after the first drain, and drain order is 0x0..0x10.
REQ-026 Forwarding on, mem_ready=0: stores 0x200←1 then 0x200←2, then load 0x202 -> ReadDataM=2, StallSB=0.
REQ-027 Forwarding off, same stimulus -> StallSB=1 until both entries drain; then ReadDataM=ReadDataMem.
REQ-028 Three buffered stores, SyncM=1, mem_ready toggling 1,0,1,1 -> StallSB=1 until count==0, then 0 in that same cycle.
REQ-029 Reset asserted while count=3 and mem_ready=0 -> next cycle count=0, SBEmpty=1, mem_req=0, and no memory write occurs.
